// File: rtl/unidirbus_pkg.sv
// Shared definitions for the 6-bit unidirectional A->B bus receiver.
package unidirbus_pkg;

  localparam int unsigned BUS_W       = 6;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_LOWMARK = 1;

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TURN  = 2'd2
  } recv_state_e;

endpackage

// File: rtl/busfifo6b.sv
// Synchronous 6-bit FIFO with registered count; head reads as zero while empty.
module busfifo6b
  import unidirbus_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [BUS_W-1:0]           wdata_i,
  output logic [BUS_W-1:0]           head_c,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  // Guards make the FIFO safe even if a caller ignores full/empty.
  assign push_ok     = push_i && (count_q < CNT_W'(DEPTH));
  assign pop_ok      = pop_i && (count_q != '0);
  assign count_nxt_c = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign count_o     = count_q;
  assign head_c      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_nxt_c;
    end
  end

endmodule

// File: rtl/unidirbusrecv6b.sv
// B-side receiver: buffers strobed words and drives flow/conflict/priority
// status back to the transmitter, plus local bus-turnaround arbitration.
module unidirbusrecv6b
  import unidirbus_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LOWMARK = DEF_LOWMARK
) (
  input  logic clk,
  input  logic reset,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic B4,
  input  logic B5,
  input  logic strobe,
  input  logic turnreq,
  input  logic pop,
  output logic flowvalve,
  output logic conflictstatus,
  output logic prioritystatus,
  output logic turngnt,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5,
  output logic dvalid,
  output logic ovrerr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  recv_state_e      state_q, state_d;
  logic             flowvalve_q, conflict_q, priority_q, turngnt_q, ovrerr_q;
  logic             push, drop;
  logic [BUS_W-1:0] wdata, head;
  logic [CNT_W-1:0] count, count_nxt;

  assign wdata = {B5, B4, B3, B2, B1, B0};
  // Accept only when the previously advertised valve was open.
  assign push  = strobe && flowvalve_q;
  assign drop  = strobe && !flowvalve_q;

  busfifo6b #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wdata),
    .head_c      (head),
    .count_o     (count),
    .count_nxt_c (count_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RECV:  if (turnreq) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!turnreq)     state_d = ST_RECV;
        else if (!strobe) state_d = ST_TURN;
      end
      ST_TURN:  if (!turnreq) state_d = ST_RECV;
      default:  state_d = ST_RECV;
    endcase
  end

  // Status flags are computed from the next state and next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RECV;
      flowvalve_q <= 1'b0;
      conflict_q  <= 1'b1;
      priority_q  <= 1'b0;
      turngnt_q   <= 1'b0;
      ovrerr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flowvalve_q <= (state_d != ST_TURN) && (count_nxt < CNT_W'(DEPTH));
      conflict_q  <= (state_d == ST_RECV);
      priority_q  <= (state_d != ST_TURN) && (count_nxt <= CNT_W'(LOWMARK));
      turngnt_q   <= (state_d == ST_TURN);
      if (drop) ovrerr_q <= 1'b1;
    end
  end

  assign flowvalve      = flowvalve_q;
  assign conflictstatus = conflict_q;
  assign prioritystatus = priority_q;
  assign turngnt        = turngnt_q;
  assign ovrerr         = ovrerr_q;
  assign dvalid         = (count != '0);
  assign {D5, D4, D3, D2, D1, D0} = head;

endmodule

// File: tb/tb_unidirbusrecv6b.sv
// Directed, table-driven bench for unidirbusrecv6b (DEPTH=4, LOWMARK=1).
module tb_unidirbusrecv6b;

  logic clk = 1'b0;
  logic reset, strobe, turnreq, pop;
  logic [5:0] b;
  logic flowvalve, conflictstatus, prioritystatus, turngnt, dvalid, ovrerr;
  logic D0, D1, D2, D3, D4, D5;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  unidirbusrecv6b #(.DEPTH(4), .LOWMARK(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .B0             (b[0]),
    .B1             (b[1]),
    .B2             (b[2]),
    .B3             (b[3]),
    .B4             (b[4]),
    .B5             (b[5]),
    .strobe         (strobe),
    .turnreq        (turnreq),
    .pop            (pop),
    .flowvalve      (flowvalve),
    .conflictstatus (conflictstatus),
    .prioritystatus (prioritystatus),
    .turngnt        (turngnt),
    .D0             (D0),
    .D1             (D1),
    .D2             (D2),
    .D3             (D3),
    .D4             (D4),
    .D5             (D5),
    .dvalid         (dvalid),
    .ovrerr         (ovrerr)
  );

  // exp packs {flowvalve, conflict, priority, turngnt, dvalid, ovrerr, D[5:0]}
  typedef struct packed {
    logic        rst;
    logic        stb;
    logic [5:0]  bw;
    logic        treq;
    logic        pp;
    logic [11:0] exp;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic stb, input logic [5:0] bw,
                              input logic treq, input logic pp,
                              input logic fv, input logic cs, input logic ps,
                              input logic tg, input logic dv, input logic ov,
                              input logic [5:0] d);
    vec_t v;
    v.rst  = rst;
    v.stb  = stb;
    v.bw   = bw;
    v.treq = treq;
    v.pp   = pp;
    v.exp  = {fv, cs, ps, tg, dv, ov, d};
    return v;
  endfunction

  function automatic logic [11:0] observe();
    return {flowvalve, conflictstatus, prioritystatus, turngnt, dvalid, ovrerr,
            D5, D4, D3, D2, D1, D0};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stb, input logic [5:0] bw,
                      input logic treq, input logic pp);
    @(negedge clk);
    reset = rst; strobe = stb; b = bw; turnreq = treq; pop = pp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gnt_wait;

    reset = 1'b1; strobe = 1'b0; turnreq = 1'b0; pop = 1'b0; b = '0;

    //                rst stb b      treq pop  fv cs ps tg dv ov d
    vecs[0]  = mk(1, 0, 6'h00, 0, 0,  0, 1, 0, 0, 0, 0, 6'h00);
    vecs[1]  = mk(0, 0, 6'h00, 0, 0,  1, 1, 1, 0, 0, 0, 6'h00);
    vecs[2]  = mk(0, 1, 6'h2A, 0, 0,  1, 1, 1, 0, 1, 0, 6'h2A);
    vecs[3]  = mk(0, 1, 6'h15, 0, 0,  1, 1, 0, 0, 1, 0, 6'h2A);
    vecs[4]  = mk(0, 1, 6'h3F, 0, 0,  1, 1, 0, 0, 1, 0, 6'h2A);
    vecs[5]  = mk(0, 1, 6'h01, 0, 0,  0, 1, 0, 0, 1, 0, 6'h2A);
    vecs[6]  = mk(0, 1, 6'h07, 0, 0,  0, 1, 0, 0, 1, 1, 6'h2A);
    vecs[7]  = mk(0, 0, 6'h00, 0, 1,  1, 1, 0, 0, 1, 1, 6'h15);
    vecs[8]  = mk(0, 0, 6'h00, 0, 1,  1, 1, 0, 0, 1, 1, 6'h3F);
    vecs[9]  = mk(0, 0, 6'h00, 0, 1,  1, 1, 1, 0, 1, 1, 6'h01);
    vecs[10] = mk(0, 0, 6'h00, 0, 1,  1, 1, 1, 0, 0, 1, 6'h00);
    vecs[11] = mk(0, 0, 6'h00, 0, 1,  1, 1, 1, 0, 0, 1, 6'h00);
    vecs[12] = mk(0, 1, 6'h0A, 0, 0,  1, 1, 1, 0, 1, 1, 6'h0A);
    vecs[13] = mk(0, 1, 6'h0B, 0, 0,  1, 1, 0, 0, 1, 1, 6'h0A);
    vecs[14] = mk(0, 1, 6'h11, 0, 1,  1, 1, 0, 0, 1, 1, 6'h0B);
    for (int i = 15; i < 22; i++)
      vecs[i] = mk(0, 1, 6'h11, 0, 1,  1, 1, 0, 0, 1, 1, 6'h11);
    // Turnaround while strobe keeps flowing (pops hold count at 2).
    vecs[22] = mk(0, 1, 6'h05, 1, 1,  1, 0, 0, 0, 1, 1, 6'h11);
    vecs[23] = mk(0, 1, 6'h06, 1, 1,  1, 0, 0, 0, 1, 1, 6'h05);
    vecs[24] = mk(0, 1, 6'h07, 1, 1,  1, 0, 0, 0, 1, 1, 6'h06);
    vecs[25] = mk(0, 0, 6'h00, 1, 0,  0, 0, 0, 1, 1, 1, 6'h06);
    vecs[26] = mk(0, 0, 6'h00, 1, 0,  0, 0, 0, 1, 1, 1, 6'h06);
    vecs[27] = mk(0, 0, 6'h00, 0, 0,  1, 1, 0, 0, 1, 1, 6'h06);
    // Reach TURN with count 3, then reset alongside push/pop.
    vecs[28] = mk(0, 1, 6'h0C, 1, 0,  1, 0, 0, 0, 1, 1, 6'h06);
    vecs[29] = mk(0, 0, 6'h00, 1, 0,  0, 0, 0, 1, 1, 1, 6'h06);
    vecs[30] = mk(1, 1, 6'h3C, 1, 1,  0, 1, 0, 0, 0, 0, 6'h00);
    vecs[31] = mk(0, 0, 6'h00, 0, 0,  1, 1, 1, 0, 0, 0, 6'h00);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].stb, vecs[i].bw, vecs[i].treq, vecs[i].pp);
      check($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Turnaround request withdrawn while still draining.
    step(0, 0, 6'h00, 1, 0);
    check("drain_cs_low", observe(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00});
    step(0, 0, 6'h00, 0, 0);
    check("drain_abort", observe(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00});

    // Grant must follow the first quiet cycle in DRAIN exactly one edge later.
    step(0, 1, 6'h2C, 1, 0);
    step(0, 1, 6'h2D, 1, 0);
    check("drain_accepts", observe(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h2C});
    gnt_wait = 0;
    do begin
      step(0, 0, 6'h00, 1, 0);
      gnt_wait++;
    end while (!turngnt && gnt_wait < 8);
    check("gnt_latency", 12'(gnt_wait), 12'd1);
    check("turn_state", observe(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h2C});
    // Strobe during TURN is dropped and flagged.
    step(0, 1, 6'h33, 1, 0);
    check("turn_drop", observe(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h2C});
    step(0, 0, 6'h00, 0, 0);
    check("turn_release", observe(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h2C});
    step(0, 0, 6'h00, 0, 1);
    check("pop_after_turn", observe(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h2D});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
